// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM stream reader.
// The optional stall counter in bram_stream_reader is enabled by defining BRAM_RD_STALL_CNT_EN.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that holds returned BRAM words (data plus last tag) until the stream consumer takes them.
// The controller never pushes into a full FIFO, so push and pop only need to work together at count 1.
module rd_skid_fifo
  import bram_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } rd_beat_t;

  logic       rd_ptr_reg;
  logic       wr_ptr_reg;
  logic [1:0] count_reg;
  rd_beat_t   head_beat;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      rd_beat_t entry_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= '{data: push_data, last: push_last};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      if (push && !pop)      count_reg <= count_reg + 2'd1;
      else if (pop && !push) count_reg <= count_reg - 2'd1;
    end
  end

  assign head_beat = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign head_data = head_beat.data;
  assign head_last = head_beat.last;
  assign count     = count_reg;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams LEN sequential words out of a 1-cycle-latency single-port BRAM onto a valid/ready port.
// Defining BRAM_RD_STALL_CNT_EN adds the stall_cycles output (cycles spent with m_valid & !m_ready).
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 784,
  parameter int DEPTH_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DEPTH_BITS-1:0] base_addr,
  input  logic [DEPTH_BITS:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  read_en,
  output logic [DEPTH_BITS-1:0] read_address,
  input  logic [WIDTH-1:0]      read_data_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last
`ifdef BRAM_RD_STALL_CNT_EN
 ,output logic [31:0]           stall_cycles
`endif
);

  rd_state_t             state_reg, state_next;
  logic [DEPTH_BITS-1:0] addr_reg;
  logic [DEPTH_BITS:0]   remain_reg;
  logic                  inflight_reg;
  logic                  inflight_last_reg;
  logic [1:0]            fifo_count;
  logic                  head_last;
  logic                  pop;
  logic [2:0]            credit;
  logic                  last_read;
  logic                  accept;

  assign pop     = m_valid & m_ready;
  assign m_valid = (fifo_count != 2'd0);
  assign m_last  = m_valid & head_last;
  assign accept  = (state_reg == IDLE) & start;

  // Words already held plus the one returning from BRAM must leave room in the 2-entry FIFO.
  assign credit    = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign read_en   = (state_reg == STREAM) && (credit < 3'd2);
  assign last_read = read_en && (remain_reg == (DEPTH_BITS+1)'(1));

  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == FINISH);
  assign read_address = addr_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (length == '0) ? FINISH : STREAM;
      STREAM:  if (last_read) state_next = DRAIN;
      DRAIN:   if (pop && m_last) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      remain_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      inflight_reg      <= read_en;
      inflight_last_reg <= last_read;
      if (accept) begin
        addr_reg   <= base_addr;
        remain_reg <= length;
      end else if (read_en) begin
        addr_reg   <= (addr_reg == DEPTH_BITS'(DEPTH - 1)) ? '0 : addr_reg + 1'b1;
        remain_reg <= remain_reg - 1'b1;
      end
    end
  end

  rd_skid_fifo #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (read_data_in),
    .push_last (inflight_last_reg),
    .pop       (pop),
    .count     (fifo_count),
    .head_data (m_data),
    .head_last (head_last)
  );

`ifdef BRAM_RD_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cnt_reg <= '0;
    end else if (m_valid && !m_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized bench for bram_stream_reader against a 1-cycle BRAM model and an address/data reference queue.
// Build with BRAM_RD_STALL_CNT_EN defined to also check stall_cycles.
module tb_bram_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 784;
  localparam int DB    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DB-1:0] base_addr;
  logic [DB:0]   length;
  logic          busy, done, read_en;
  logic [DB-1:0] read_address;
  logic [7:0]    read_data_in = 8'h00;
  logic          m_valid, m_ready, m_last;
  logic [7:0]    m_data;
`ifdef BRAM_RD_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_BITS(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .read_en      (read_en),
    .read_address (read_address),
    .read_data_in (read_data_in),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
`ifdef BRAM_RD_STALL_CNT_EN
   ,.stall_cycles (stall_cycles)
`endif
  );

  // BRAM model: 1-cycle registered read, mem[i] = low byte of i
  logic [7:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
  always @(posedge clk) if (read_en) read_data_in <= mem[read_address];

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: records handshaken beats, read/valid/done activity and checks hold-under-stall
  int         cyc = 0;
  logic [7:0] got_d [$];
  logic       got_l [$];
  int         got_c [$];
  int         rd_n, vld_n, done_n, first_rd, first_vld, done_cyc, start_cyc;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) start_cyc = cyc + 1;
      if (read_en) begin
        if (rd_n == 0) first_rd = cyc;
        rd_n++;
      end
      if (m_valid) begin
        if (vld_n == 0) first_vld = cyc;
        vld_n++;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (prev_stall) begin
        check_eq("hold_valid", 32'(m_valid), 32'd1);
        check_eq("hold_data", 32'(m_data), 32'(prev_d));
        check_eq("hold_last", 32'(m_last), 32'(prev_l));
      end
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        got_c.push_back(cyc);
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
    end
  end

  // Consumer: 0 always ready, 1 toggling, 2 random ~30% stalls, 3 one 7-cycle stall after the 4th beat
  int   ready_mode  = 0;
  int   stall_left  = 0;
  logic stall_armed = 1'b0;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: m_ready = ~m_ready;
        2: m_ready = ($urandom_range(99) >= 30);
        3: begin
          if (got_d.size() == 0) stall_armed = 1'b1;
          if (stall_armed && got_d.size() == 4) begin
            stall_left  = 7;
            stall_armed = 1'b0;
          end
          if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic start_xfer(input int b, input int l);
    @(posedge clk);
    #1;
    got_d.delete(); got_l.delete(); got_c.delete();
    rd_n = 0; vld_n = 0; done_n = 0;
    first_rd = -1; first_vld = -1; done_cyc = -1; start_cyc = -1;
    start     = 1'b1;
    base_addr = b[DB-1:0];
    length    = l[DB:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_n == 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({name, "_done_seen"}, 32'(done_n > 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reference: beat i of a transfer carries mem[(base+i) mod DEPTH], last on i == len-1
  task automatic check_beats(input string name, input int b, input int l);
    check_eq({name, "_count"}, 32'(got_d.size()), 32'(l));
    check_eq({name, "_reads"}, 32'(rd_n), 32'(l));
    check_eq({name, "_done_n"}, 32'(done_n), 32'd1);
    check_eq({name, "_idle"}, 32'(busy), 32'd0);
    for (int i = 0; i < got_d.size() && i < l; i++) begin
      check_eq($sformatf("%s_d%0d", name, i), 32'(got_d[i]), 32'(((b + i) % DEPTH) & 8'hff));
      check_eq($sformatf("%s_l%0d", name, i), 32'(got_l[i]), 32'(i == l - 1));
    end
    if (l > 0 && got_c.size() > 0)
      check_eq({name, "_done_at"}, 32'(done_cyc), 32'(got_c[got_c.size()-1] + 1));
    $display("xfer %s base=%0d len=%0d beats=%0d reads=%0d done=%0d", name, b, l, got_d.size(), rd_n, done_n);
  endtask

  task automatic check_idle_outputs(input string name);
    check_eq({name, "_busy"}, 32'(busy), 32'd0);
    check_eq({name, "_done"}, 32'(done), 32'd0);
    check_eq({name, "_rden"}, 32'(read_en), 32'd0);
    check_eq({name, "_valid"}, 32'(m_valid), 32'd0);
    check_eq({name, "_last"}, 32'(m_last), 32'd0);
    check_eq({name, "_addr"}, 32'(read_address), 32'd0);
    check_eq({name, "_data"}, 32'(m_data), 32'd0);
`ifdef BRAM_RD_STALL_CNT_EN
    check_eq({name, "_stall"}, stall_cycles, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Latency and full-rate streaming
    ready_mode = 0;
    start_xfer(0, 4);
    wait_done("basic");
    check_beats("basic", 0, 4);
    check_eq("basic_rd_lat", 32'(first_rd - start_cyc), 32'd0);
    check_eq("basic_vld_lat", 32'(first_vld - start_cyc), 32'd2);
    for (int i = 1; i < got_c.size(); i++)
      check_eq($sformatf("basic_rate%0d", i), 32'(got_c[i] - got_c[0]), 32'(i));

    // Address wrap
    start_xfer(782, 4);
    wait_done("wrap");
    check_beats("wrap", 782, 4);

    // Backpressure patterns
    ready_mode = 1;
    start_xfer(300, 16);
    wait_done("toggle");
    check_beats("toggle", 300, 16);
    ready_mode = 2;
    start_xfer(770, 16);
    wait_done("rand30");
    check_beats("rand30", 770, 16);

    // Zero-length transfer
    ready_mode = 0;
    start_xfer(5, 0);
    wait_done("len0");
    check_beats("len0", 5, 0);
    check_eq("len0_valid", 32'(vld_n), 32'd0);
    check_eq("len0_lat", 32'((done_cyc - start_cyc) inside {[0:1]}), 32'd1);

    // Reset in the middle of a transfer, then restart
    start_xfer(0, 20);
    begin
      int n = 0;
      while (got_d.size() < 5 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      check_eq("mid_five_beats", 32'(got_d.size() >= 5), 32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    start_xfer(100, 2);
    wait_done("restart");
    check_beats("restart", 100, 2);

    // Start while busy is ignored; one 7-cycle stall mid-stream
    ready_mode = 3;
    start_xfer(10, 16);
    repeat (3) @(posedge clk);
    #1;
    check_eq("ign_busy", 32'(busy), 32'd1);
    start = 1'b1; base_addr = 10'd500; length = 11'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore");
    check_beats("ignore", 10, 16);
`ifdef BRAM_RD_STALL_CNT_EN
    check_eq("stall_seven", stall_cycles, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    check_eq("stall_hold", stall_cycles, 32'd7);
`endif

    // Random transfers
    for (int k = 0; k < 6; k++) begin
      int b, l;
      b = int'($urandom_range(DEPTH - 1));
      l = int'($urandom_range(40, 1));
      ready_mode = int'($urandom_range(2));
      start_xfer(b, l);
      wait_done($sformatf("rnd%0d", k));
      check_beats($sformatf("rnd%0d", k), b, l);
`ifdef BRAM_RD_STALL_CNT_EN
      if (ready_mode == 0) check_eq($sformatf("rnd%0d_stall", k), stall_cycles, 32'd0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
